nand_delay_meter: RTL and testbench

NAND_DELAY_METER -- requirements
Module: nand_delay_meter

---
 rtl/nand_delay_meter_if.sv | 28 ++
 rtl/nand_delay_meter.sv | 120 ++++++++++++
 tb/tb_nand_delay_meter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/nand_delay_meter_if.sv
// rtl/nand_delay_meter_if.sv - stimulus, observed NAND outputs and measurement results for nand_delay_meter
interface nand_delay_meter_if #(
  parameter int CNT_W = 8
);
  logic             a;
  logic             b;
  logic             w1;
  logic             w3;
  logic             busy;
  logic             done;
  logic             abort;
  logic [CNT_W-1:0] d1;
  logic [CNT_W-1:0] d3;
  logic [CNT_W-1:0] diff;
  logic             d1_slower;
  logic             timeout;
  logic [CNT_W-1:0] max_diff;

  modport master (
    output a, b, w1, w3,
    input  busy, done, abort, d1, d3, diff, d1_slower, timeout, max_diff
  );

  modport slave (
    input  a, b, w1, w3,
    output busy, done, abort, d1, d3, diff, d1_slower, timeout, max_diff
  );
endinterface

// File: rtl/nand_delay_meter.sv
// rtl/nand_delay_meter.sv - measures settle delay of two NAND implementations after each {a,b} change
// Optional max_diff history register is built when NAND_DM_HIST_EN is defined.
module nand_delay_meter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input logic               clk,
  input logic               rst,
  nand_delay_meter_if.slave bus
);
  localparam logic [CNT_W-1:0] TMO_K = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_K = CNT_W'(1);

  typedef enum logic {IDLE = 1'b0, MEAS = 1'b1} state_t;

  state_t           state, state_next;
  logic [1:0]       prev_ab, ab;
  logic             exp_q, cap1, cap3;
  logic [CNT_W-1:0] k, m1, m3, k_inc, val1, val3, diff_new;
  logic [CNT_W-1:0] d1_q, d3_q, diff_q;
  logic             change, hit1, hit3, got1, got3, finish, tmo;
  logic             done_next, abort_next;
  logic             done_q, abort_q, slower_q, timeout_q;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    ab         = {bus.a, bus.b};
    change     = (ab != prev_ab);
    k_inc      = k + ONE_K;
    hit1       = (state == MEAS) && !cap1 && (bus.w1 == exp_q);
    hit3       = (state == MEAS) && !cap3 && (bus.w3 == exp_q);
    got1       = cap1 | hit1;
    got3       = cap3 | hit3;
    // Anything still uncaptured on the final edge reports the timeout value.
    val1       = cap1 ? m1 : (hit1 ? k_inc : TMO_K);
    val3       = cap3 ? m3 : (hit3 ? k_inc : TMO_K);
    diff_new   = (val1 > val3) ? (val1 - val3) : (val3 - val1);
    // A fresh input change always wins over a completing measurement.
    finish     = (state == MEAS) && !change && ((got1 && got3) || (k_inc == TMO_K));
    tmo        = !(got1 && got3);
    done_next  = finish;
    abort_next = (state == MEAS) && change;
    state_next = state;
    if (change)      state_next = MEAS;
    else if (finish) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ab   <= 2'b00;
      exp_q     <= 1'b0;
      k         <= '0;
      cap1      <= 1'b0;
      cap3      <= 1'b0;
      m1        <= '0;
      m3        <= '0;
      d1_q      <= '0;
      d3_q      <= '0;
      diff_q    <= '0;
      slower_q  <= 1'b0;
      timeout_q <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      prev_ab <= ab;
      done_q  <= done_next;
      abort_q <= abort_next;
      if (change) begin
        exp_q <= ~(bus.a & bus.b);
        k     <= '0;
        cap1  <= 1'b0;
        cap3  <= 1'b0;
      end else if (state == MEAS) begin
        k <= k_inc;
        if (hit1) begin
          cap1 <= 1'b1;
          m1   <= k_inc;
        end
        if (hit3) begin
          cap3 <= 1'b1;
          m3   <= k_inc;
        end
      end
      // Published results only move on a done, so aborts leave them intact.
      if (finish) begin
        d1_q      <= val1;
        d3_q      <= val3;
        diff_q    <= diff_new;
        slower_q  <= (val1 > val3);
        timeout_q <= tmo;
      end
    end
  end

  assign bus.busy      = (state == MEAS);
  assign bus.done      = done_q;
  assign bus.abort     = abort_q;
  assign bus.d1        = d1_q;
  assign bus.d3        = d3_q;
  assign bus.diff      = diff_q;
  assign bus.d1_slower = slower_q;
  assign bus.timeout   = timeout_q;

`ifdef NAND_DM_HIST_EN
  logic [CNT_W-1:0] max_q;

  always_ff @(posedge clk) begin
    if (rst)                            max_q <= '0;
    else if (finish && diff_new > max_q) max_q <= diff_new;
  end

  assign bus.max_diff = max_q;
`else
  assign bus.max_diff = '0;
`endif
endmodule

// File: tb/tb_nand_delay_meter.sv
// tb/tb_nand_delay_meter.sv - randomized self-checking bench for nand_delay_meter
module tb_nand_delay_meter;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nand_delay_meter_if #(.CNT_W(CNT_W)) ifc ();

  nand_delay_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  int total = 0;
  int bad   = 0;

  logic [1:0] cur_ab;
  int m_d1, m_d3, m_diff, m_max, m_slow, m_tmo;

  task automatic check_eq(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_model();
    m_d1 = 0; m_d3 = 0; m_diff = 0; m_max = 0; m_slow = 0; m_tmo = 0;
  endtask

  task automatic check_results(input string tag);
    check_eq({tag, "_d1"}, int'(ifc.d1), m_d1);
    check_eq({tag, "_d3"}, int'(ifc.d3), m_d3);
    check_eq({tag, "_diff"}, int'(ifc.diff), m_diff);
    check_eq({tag, "_slower"}, int'(ifc.d1_slower), m_slow);
    check_eq({tag, "_timeout"}, int'(ifc.timeout), m_tmo);
`ifdef NAND_DM_HIST_EN
    check_eq({tag, "_max"}, int'(ifc.max_diff), m_max);
`else
    check_eq({tag, "_max"}, int'(ifc.max_diff), 0);
`endif
  endtask

  task automatic drive_change(input int want_ab);
    logic [1:0] nab;
    if (want_ab >= 0) nab = 2'(want_ab);
    else begin
      nab = 2'($urandom_range(0, 3));
      while (nab == cur_ab) nab = 2'($urandom_range(0, 3));
    end
    cur_ab = nab;
    ifc.a  = nab[1];
    ifc.b  = nab[0];
    ifc.w1 = 1'($urandom);
    ifc.w3 = 1'($urandom);
  endtask

  // t1/t3: first cycle after the change at which each output shows the NAND value.
  task automatic run_meas(input int want_ab, input int t1, input int t3, input int abort_at);
    int  e1, e3, ke;
    logic expb;
    drive_change(want_ab);
    step();
    check_eq("start_busy", int'(ifc.busy), 1);
    check_eq("start_done", int'(ifc.done), 0);
    check_eq("start_abort", int'(ifc.abort), 0);
    e1 = (t1 <= TIMEOUT) ? t1 : TIMEOUT;
    e3 = (t3 <= TIMEOUT) ? t3 : TIMEOUT;
    ke = (t1 <= TIMEOUT && t3 <= TIMEOUT) ? ((e1 > e3) ? e1 : e3) : TIMEOUT;
    for (int k = 1; k <= ke; k++) begin
      expb = ~(cur_ab[1] & cur_ab[0]);
      if (k == abort_at) begin
        drive_change(-1);
        step();
        check_eq("abort_pulse", int'(ifc.abort), 1);
        check_eq("abort_done", int'(ifc.done), 0);
        check_eq("abort_busy", int'(ifc.busy), 1);
        check_results("abort_held");
        abort_at = 0;
        k = 0;
        continue;
      end
      ifc.w1 = (k < t1) ? ~expb : ((k == t1) ? expb : 1'($urandom));
      ifc.w3 = (k < t3) ? ~expb : ((k == t3) ? expb : 1'($urandom));
      step();
      check_eq("meas_abort", int'(ifc.abort), 0);
      if (k == ke) begin
        check_eq("end_done", int'(ifc.done), 1);
        m_d1   = e1;
        m_d3   = e3;
        m_diff = (e1 > e3) ? e1 - e3 : e3 - e1;
        m_slow = (e1 > e3) ? 1 : 0;
        m_tmo  = (t1 > TIMEOUT || t3 > TIMEOUT) ? 1 : 0;
        if (m_diff > m_max) m_max = m_diff;
        check_results("end");
      end else if (k % 7 == 0 || k == ke - 1) begin
        check_eq("mid_done", int'(ifc.done), 0);
        check_eq("mid_busy", int'(ifc.busy), 1);
      end
    end
    step();
    check_eq("after_done", int'(ifc.done), 0);
    check_eq("after_busy", int'(ifc.busy), 0);
    check_results("hold");
  endtask

  initial begin
    int t1, t3, ab_at;
    ifc.a = 1'b0; ifc.b = 1'b0; ifc.w1 = 1'b0; ifc.w3 = 1'b0;
    cur_ab = 2'b00;
    clear_model();
    rst = 1'b1;
    step();
    step();
    check_eq("rst_busy", int'(ifc.busy), 0);
    check_eq("rst_done", int'(ifc.done), 0);
    check_eq("rst_abort", int'(ifc.abort), 0);
    check_results("rst");
    rst = 1'b0;
    step();
    check_eq("idle_busy", int'(ifc.busy), 0);

    run_meas(2'b01, 10, 8, 0);
    run_meas(2'b11, 8, 7, 0);
    run_meas(2'b10, 5, 8, 0);
    run_meas(-1, 1, 1, 0);
    run_meas(-1, TIMEOUT, TIMEOUT, 0);
    run_meas(-1, 50, 300, 0);
    run_meas(-1, 9, 12, 4);
    run_meas(-1, 5, 5, 5);

    for (int i = 0; i < 40; i++) begin
      t1    = ($urandom_range(0, 7) == 0) ? 250 : int'($urandom_range(1, 30));
      t3    = ($urandom_range(0, 7) == 0) ? 250 : int'($urandom_range(1, 30));
      ab_at = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 30)) : 0;
      run_meas(-1, t1, t3, ab_at);
    end

    drive_change(-1);
    step();
    for (int k = 1; k <= 3; k++) begin
      ifc.w1 = cur_ab[1] & cur_ab[0];
      ifc.w3 = cur_ab[1] & cur_ab[0];
      step();
    end
    check_eq("pre_rst_busy", int'(ifc.busy), 1);
    rst   = 1'b1;
    ifc.a = 1'b0;
    ifc.b = 1'b0;
    step();
    cur_ab = 2'b00;
    clear_model();
    check_eq("mid_rst_busy", int'(ifc.busy), 0);
    check_eq("mid_rst_done", int'(ifc.done), 0);
    check_eq("mid_rst_abort", int'(ifc.abort), 0);
    check_results("mid_rst");
    rst = 1'b0;
    step();
    check_eq("post_rst_busy", int'(ifc.busy), 0);
    check_eq("post_rst_done", int'(ifc.done), 0);
    run_meas(-1, 3, 6, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
